sram_handshake_responder: RTL and testbench
===========================================

# sram_handshake_responder

Memory-side responder for the CPU's valid/ack memory request protocol (req valid/ack, read-data valid/ack). Accepts one word-aligned read or byte-strobed write at a time from the CPU core. Holds a local word array and returns read data after a fixed, parameterised latency. Sits in the SoC wrapper in place of the zero-wait SRAM so the core's stall and handshake paths can be exercised.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; the array holds 2**ADDR_WIDTH 32-bit words.
- LATENCY, 2, clock edges from request acceptance to response or write commit; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  the CPU presents a request.
- req_ack  out  1  the responder accepts a request this cycle.
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_wen  in  4  byte write strobes; 4'b0000 means read; bit i writes byte lane i (bits [8i+7:8i]).
- req_wdata  in  32  write data.
- rdata  out  32  read data.
- rdata_valid  out  1  rdata holds a valid read response.
- rdata_ack  in  1  the CPU consumes the response.

## Operation
- State machine with three states:
  - IDLE: req_ack=1. When req_valid&&req_ack is sampled at an edge (the accept edge), latch addr/wen/wdata, load cnt=LATENCY-1, and go to WAIT.
  - WAIT: if cnt!=0, decrement cnt. If cnt==0:
    - read: load rdata from the array and go to RESP.
    - write: commit the strobed bytes to the array and go to IDLE.
  - RESP: rdata_valid=1. rdata is held stable until rdata_ack is sampled high, then go to IDLE.
- Only one transaction is outstanding at a time. req_ack=0 in WAIT and RESP. A request presented there is held by the CPU and is not lost.
- Word index is latched req_addr[ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses alias modulo the array size.
- Writes with partial strobes leave the unstrobed bytes unchanged.
- Since there is one outstanding transaction, a read accepted after a write's commit always observes that write.
- rdata_ack outside RESP is ignored.
- Reset values: state=IDLE, cnt=0, rdata=0, rdata_valid=0. req_ack is forced to 0 while rst is asserted and reads 1 in the first cycle after deassertion.
- The array contents are not reset.
- Reset mid-operation: return to IDLE immediately.
  - A pending write whose commit edge has not occurred is dropped.
  - A pending read response is discarded.

## Timing
- req_ack is a combinational function of state and rst only; it never depends on req_valid.
- Read: with accept edge E0, rdata_valid rises after edge E_LATENCY.
  - LATENCY=1 gives a response in the cycle after one WAIT cycle.
- Write: the array is updated at edge E_LATENCY; req_ack reasserts in the following cycle.
- Response to next accept: rdata_ack sampled at edge R sends the FSM to IDLE. The earliest next accept is edge R+1.
- Read throughput is therefore LATENCY+2 cycles per read with an immediate ack. Write throughput is LATENCY+1 cycles per write.
- rdata and rdata_valid are registered outputs.

## Structure
- Package mem_resp_pkg holds:
  - the state typedef (IDLE, WAIT, RESP);
  - localparam LAT_W=4 for cnt width;
  - a function for byte-lane merge (old word, new word, strobe -> merged word).
- Sub-module bram_wstrb: a single-port 2**ADDR_WIDTH x 32 array with 4-bit byte write enables and registered read.
  - The FSM issues the read or write in the WAIT cycle with cnt==0.
- Parameter assertion: 1 <= LATENCY <= 15.

## Test plan
- Write then read, LATENCY=2, ADDR_WIDTH=10:
  - Write 0x0000_0010 data 0xDEADBEEF wen 4'hF, then read 0x10.
  - Required: rdata=0xDEADBEEF, with rdata_valid rising 2 edges after the read accept.
- Partial strobe:
  - Write 0x11223344 to 0x20 with wen 4'hF, then 0xAABBCCDD with wen 4'b0101, then read 0x20.
  - Required: rdata=0x11BB33DD.
- Backpressure on the response:
  - Hold rdata_ack=0 for 5 cycles after rdata_valid.
  - Required: rdata stable, req_ack=0 throughout, and a new req_valid not accepted until one edge after the ack.
- Aliasing and latency sweep:
  - For LATENCY in {1,15}, write 0x5 to 0x1000 (index 0), then read 0x0.
  - Required: rdata=0x5, with response latency exactly LATENCY edges.
- Reset mid-write:
  - LATENCY=4, mem[0x40]=0x1. Accept a write of 0x2 to 0x40, then assert rst for one cycle after edge E2. Read 0x40 after reset.
  - Required: rdata=0x1, and rdata_valid=0 during reset.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the SRAM handshake responder.
// Holds the FSM state type, counter width and byte-lane merge.
package mem_resp_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] m;
        m = old_w;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bram_wstrb.sv
// Single-port word array with byte write enables.
// Read data is registered and held until the next read.
module bram_wstrb
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**ADDR_WIDTH];
    logic [31:0] rd_q;
    logic [31:0] rd_d;

    // Capture a new word only on a read; otherwise hold
    always_comb begin
        rd_d = rd_q;
        if (re) begin
            rd_d = mem_q[addr];
        end
    end

    // Read data register, cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    // Array storage is never reset; strobed bytes only
    always_ff @(posedge clk) begin
        if (|we) begin
            mem_q[addr] <= byte_merge(mem_q[addr], wdata, we);
        end
    end

    assign rdata = rd_q;

endmodule

// File: rtl/sram_handshake_responder.sv
// Memory-side responder for the CPU valid/ack request protocol.
// One transaction in flight, fixed latency to response or commit.
module sram_handshake_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ack,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic        rdata_ack
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("LATENCY must be within 1..15");
    end

    state_t                state_q, state_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            wen_q, wen_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  mem_re;
    logic [3:0]            mem_we;

    logic unused_addr_bits;
    assign unused_addr_bits =
        ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

    // Accept only in IDLE, and never while reset is held
    assign req_ack = (state_q == IDLE) && !rst;

    // Next-state, latch and array command logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        rvalid_d = rvalid_q;
        mem_re   = 1'b0;
        mem_we   = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ack) begin
                    addr_d  = req_addr[ADDR_WIDTH+1:2];
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    cnt_d   = LAT_W'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (wen_q == 4'b0000) begin
                    mem_re   = 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    mem_we  = wen_q;
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (rdata_ack) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // Control and request-latch registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wen_q    <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // A commit coinciding with reset is dropped
    bram_wstrb #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bram (
        .clk   (clk),
        .rst   (rst),
        .re    (mem_re),
        .we    (rst ? 4'b0000 : mem_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign rdata_valid = rvalid_q;

endmodule

// File: tb/tb_sram_handshake_responder.sv
// Bench for sram_handshake_responder at LATENCY 2, 1, 15 and 4.
// Directed cases plus random traffic against a word-array model.
module tb_sram_handshake_responder;

    logic        clk = 1'b0;
    logic        rst         [4];
    logic        req_valid   [4];
    logic        req_ack     [4];
    logic [31:0] req_addr    [4];
    logic [3:0]  req_wen     [4];
    logic [31:0] req_wdata   [4];
    logic [31:0] rdata       [4];
    logic        rdata_valid [4];
    logic        rdata_ack   [4];

    logic [31:0] mdl [4][1024];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 :
                           (g == 2) ? 15 : 4;
        sram_handshake_responder #(
            .ADDR_WIDTH(10),
            .LATENCY   (L)
        ) u_dut (
            .clk         (clk),
            .rst         (rst[g]),
            .req_valid   (req_valid[g]),
            .req_ack     (req_ack[g]),
            .req_addr    (req_addr[g]),
            .req_wen     (req_wen[g]),
            .req_wdata   (req_wdata[g]),
            .rdata       (rdata[g]),
            .rdata_valid (rdata_valid[g]),
            .rdata_ack   (rdata_ack[g])
        );
    end

    function automatic int lat_of(input int k);
        case (k)
            0: return 2;
            1: return 1;
            2: return 15;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction with latency and handshake checks
    task automatic txn(input int k, input logic [31:0] addr,
                       input logic [3:0] wen, input logic [31:0] wd,
                       input int hold, output logic [31:0] rd);
        int n;
        int idx;
        logic [31:0] exp;
        idx = int'(addr[11:2]);
        rd = '0;
        @(negedge clk);
        req_valid[k] = 1'b1;
        req_addr[k]  = addr;
        req_wen[k]   = wen;
        req_wdata[k] = wd;
        n = 0;
        while (!req_ack[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("accept_d%0d", k), 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        n = 0;
        if (wen == 4'b0000) begin
            while (!rdata_valid[k] && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check($sformatf("rd_lat_d%0d", k), n, lat_of(k));
            exp = mdl[k][idx];
            rd = rdata[k];
            check($sformatf("rd_data_d%0d", k), rdata[k], exp);
            req_valid[k] = 1'b1;
            req_addr[k]  = $urandom;
            req_wen[k]   = 4'b0000;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check($sformatf("bp_valid_d%0d", k), rdata_valid[k], 1);
                check($sformatf("bp_data_d%0d", k), rdata[k], exp);
                check($sformatf("bp_ack_d%0d", k), req_ack[k], 0);
            end
            rdata_ack[k] = 1'b1;
            @(posedge clk);
            #1;
            rdata_ack[k] = 1'b0;
            req_valid[k] = 1'b0;
            check($sformatf("post_valid_d%0d", k), rdata_valid[k], 0);
            check($sformatf("post_ack_d%0d", k), req_ack[k], 1);
        end else begin
            while (!req_ack[k] && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check($sformatf("wr_lat_d%0d", k), n, lat_of(k));
            for (int b = 0; b < 4; b++) begin
                if (wen[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int idx;
        logic [3:0] w;
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1;
            req_valid[k] = 1'b0;
            req_addr[k] = '0;
            req_wen[k] = '0;
            req_wdata[k] = '0;
            rdata_ack[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_req_ack", req_ack[k], 0);
            check("rst_rvalid", rdata_valid[k], 0);
            check("rst_rdata", rdata[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) check("post_rst_ack", req_ack[k], 1);

        txn(0, 32'h10, 4'hF, 32'hDEADBEEF, 0, rd);
        txn(0, 32'h10, 4'h0, 32'h0, 0, rd);
        check("wr_rd_const", rd, 32'hDEADBEEF);
        txn(0, 32'h20, 4'hF, 32'h11223344, 0, rd);
        txn(0, 32'h20, 4'b0101, 32'hAABBCCDD, 0, rd);
        txn(0, 32'h20, 4'h0, 32'h0, 5, rd);
        check("partial_const", rd, 32'h11BB33DD);

        for (int k = 1; k < 3; k++) begin
            txn(k, 32'h1000, 4'hF, 32'h5, 0, rd);
            txn(k, 32'h0, 4'h0, 32'h0, 1, rd);
            check($sformatf("alias_const_d%0d", k), rd, 32'h5);
        end

        txn(3, 32'h40, 4'hF, 32'h1, 0, rd);
        @(negedge clk);
        req_valid[3] = 1'b1;
        req_addr[3]  = 32'h40;
        req_wen[3]   = 4'hF;
        req_wdata[3] = 32'h2;
        check("mw_ready", req_ack[3], 1);
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst[3] = 1'b1;
        #1;
        check("mw_rst_rvalid", rdata_valid[3], 0);
        check("mw_rst_ack", req_ack[3], 0);
        @(posedge clk);
        #1;
        check("mw_rst_rvalid2", rdata_valid[3], 0);
        rst[3] = 1'b0;
        txn(3, 32'h40, 4'h0, 32'h0, 0, rd);
        check("mw_dropped", rd, 32'h1);

        @(negedge clk);
        req_valid[3] = 1'b1;
        req_addr[3]  = 32'h40;
        req_wen[3]   = 4'h0;
        @(posedge clk);
        #1;
        req_valid[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst[3] = 1'b1;
        #1;
        check("mr_rst_rvalid", rdata_valid[3], 0);
        check("mr_rst_rdata", rdata[3], 0);
        @(negedge clk);
        rst[3] = 1'b0;
        #1;
        check("mr_idle", req_ack[3], 1);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) begin
                txn(k, 32'(i * 4), 4'hF, $urandom, 0, rd);
            end
            for (int i = 0; i < 25; i++) begin
                idx = $urandom_range(0, 15);
                w = ($urandom_range(0, 2) == 0) ? 4'h0
                                                : 4'($urandom_range(0, 15));
                txn(k, (32'($urandom_range(0, 255)) << 12) |
                       32'(idx * 4) | 32'($urandom_range(0, 3)),
                    w, $urandom, $urandom_range(0, 3), rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
